// File: rtl/pwm_multi.sv
// pwm_multi -- multi-channel PWM generator sharing one period counter.
//
// Modes (selected by `mode`, taken up only on a period boundary):
//   00 edge-aligned   : cnt runs 0..period, output high while duty > cnt
//   01 center-aligned : cnt runs 0..period..1, output high while duty > cnt
//   10 sigma-delta    : per-channel accumulator, output is the carry
//   11 reserved       : outputs low, counter and accumulators frozen
//
// Duty values are written into per-channel shadow registers at any time.
// They are copied into the active (compare) registers, together with mode
// and period, only on a boundary edge. This keeps periods glitch-free.
//
// Optional feature: define PWM_POLARITY_EN to add a per-channel `polarity`
// input that inverts the corresponding output. It is latched on boundaries.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   mode       in   [1:0] operating mode (see above)
//   period     in   [WIDTH-1:0] terminal count of the shared counter
//   duty_wr    in   write strobe for shadow duty register ch_sel
//   ch_sel     in   channel addressed by duty_wr; out-of-range writes are dropped
//   duty_in    in   [WIDTH-1:0] duty value to write
//   polarity   in   [CHANNELS-1:0] output inversion (PWM_POLARITY_EN only)
//   pwm_out    out  [CHANNELS-1:0] registered PWM outputs
//   period_end out  one-cycle pulse after each boundary (edge/center modes)
module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [WIDTH-1:0]    period,
  input  logic                duty_wr,
  input  logic [SEL_W-1:0]    ch_sel,
  input  logic [WIDTH-1:0]    duty_in,
`ifdef PWM_POLARITY_EN
  input  logic [CHANNELS-1:0] polarity,
`endif
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_end
);

  typedef enum logic [1:0] {
    MODE_EDGE   = 2'b00,
    MODE_CENTER = 2'b01,
    MODE_SD     = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  mode_t               act_mode_reg;
  logic [WIDTH-1:0]    act_period_reg;
  logic [WIDTH-1:0]    cnt_reg;
  logic [WIDTH-1:0]    cnt_next;
  logic                dir_down_reg;
  logic                dir_down_next;
  logic                boundary;
  logic                mode_change;
  logic [CHANNELS-1:0] raw_next;
  logic [CHANNELS-1:0] pol_eff;
  logic [CHANNELS-1:0] pwm_reg;
  logic                period_end_reg;

  // Counter sequencing and boundary detection, all from the active copies.
  always_comb begin
    boundary      = 1'b1;
    cnt_next      = '0;
    dir_down_next = 1'b0;
    case (act_mode_reg)
      MODE_EDGE: begin
        boundary = (cnt_reg == act_period_reg);
        cnt_next = boundary ? '0 : cnt_reg + 1'b1;
      end
      MODE_CENTER: begin
        // The boundary is the edge whose next count is 0. With period==1
        // the sequence is just 0,1, so the top itself is that edge.
        if (act_period_reg == '0)
          boundary = 1'b1;
        else if (dir_down_reg)
          boundary = (cnt_reg == WIDTH'(1));
        else
          boundary = (act_period_reg == WIDTH'(1)) && (cnt_reg == act_period_reg);

        if (boundary) begin
          cnt_next      = '0;
          dir_down_next = 1'b0;
        end else if (dir_down_reg || (cnt_reg == act_period_reg)) begin
          cnt_next      = cnt_reg - 1'b1;
          dir_down_next = 1'b1;
        end else begin
          cnt_next      = cnt_reg + 1'b1;
          dir_down_next = 1'b0;
        end
      end
      default: begin
        // Sigma-delta and reserved: counter parked at 0, every edge is a
        // boundary so new settings are picked up immediately.
        boundary      = 1'b1;
        cnt_next      = '0;
        dir_down_next = 1'b0;
      end
    endcase
    mode_change = boundary && (mode != act_mode_reg);
  end

  // Per-channel shadow/active duty, accumulator and compare.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : ch_g
      logic [WIDTH-1:0] shadow_reg;
      logic [WIDTH-1:0] active_reg;
      // Low WIDTH bits of the WIDTH+1 bit accumulator; its carry bit is
      // registered straight into pwm_out.
      logic [WIDTH-1:0] acc_reg;
      logic [WIDTH:0]   acc_sum;

      assign acc_sum = {1'b0, acc_reg} + {1'b0, active_reg};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_reg <= '0;
          active_reg <= '0;
          acc_reg    <= '0;
        end else begin
          if (duty_wr && (ch_sel == SEL_W'(gi)))
            shadow_reg <= duty_in;
          // Non-blocking: a write on the boundary edge waits for the next one.
          if (boundary)
            active_reg <= shadow_reg;
          if (mode_change)
            acc_reg <= '0;
          else if (act_mode_reg == MODE_SD)
            acc_reg <= acc_sum[WIDTH-1:0];
        end
      end

      assign raw_next[gi] =
        ((act_mode_reg == MODE_EDGE) || (act_mode_reg == MODE_CENTER)) ? (active_reg > cnt_reg) :
        (act_mode_reg == MODE_SD) ? acc_sum[WIDTH] : 1'b0;
    end
  endgenerate

`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0] pol_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pol_reg <= '0;
    else if (boundary)
      pol_reg <= polarity;
  end

  assign pol_eff = pol_reg;
`else
  assign pol_eff = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg        <= '0;
      dir_down_reg   <= 1'b0;
      act_mode_reg   <= MODE_EDGE;
      act_period_reg <= '0;
      pwm_reg        <= '0;
      period_end_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      dir_down_reg <= dir_down_next;
      if (boundary) begin
        act_mode_reg   <= mode_t'(mode);
        act_period_reg <= period;
      end
      pwm_reg        <= raw_next ^ pol_eff;
      period_end_reg <= boundary &&
                        ((act_mode_reg == MODE_EDGE) || (act_mode_reg == MODE_CENTER));
    end
  end

  assign pwm_out    = pwm_reg;
  assign period_end = period_end_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi -- directed self-checking bench for pwm_multi (WIDTH=8,
// CHANNELS=4). Outputs are sampled on the falling edge; S_k denotes the
// sample after the k-th rising edge following reset release.
module tb_pwm_multi;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          mode = 2'd0;
  logic [WIDTH-1:0]    period = '0;
  logic                duty_wr = 1'b0;
  logic [1:0]          ch_sel = 2'd0;
  logic [WIDTH-1:0]    duty_in = '0;
  logic [CHANNELS-1:0] pwm_out;
  logic                period_end;
`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0] polarity = '0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Center-mode count compared at sample S_k for k>=10, indexed by (k-10)%8.
  int ctab [8] = '{0, 1, 2, 3, 4, 3, 2, 1};

  always #5 clk = ~clk;

  pwm_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .period     (period),
    .duty_wr    (duty_wr),
    .ch_sel     (ch_sel),
    .duty_in    (duty_in),
`ifdef PWM_POLARITY_EN
    .polarity   (polarity),
`endif
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [WIDTH-1:0] d);
    duty_wr = 1'b1;
    ch_sel  = ch;
    duty_in = d;
  endtask

  // Reset for two cycles, then release with the given mode/period.
  task automatic restart(input logic [1:0] m, input logic [WIDTH-1:0] p);
    @(negedge clk);
    rst     = 1'b1;
    duty_wr = 1'b0;
    repeat (2) @(negedge clk);
    mode   = m;
    period = p;
    rst    = 1'b0;
    cyc    = 0;
  endtask

  initial begin
    logic [3:0] exp_pwm;
    logic       exp_pe;

    // Reset state
    @(negedge clk);
    chk("reset_pwm", pwm_out, 4'h0);
    chk("reset_pe", period_end, 1'b0);

    // Edge mode, period 9: ch0=3, ch1=0, ch2=10; ch0 rewritten to 7 mid-period
    restart(2'd0, 8'd9);
    wr(2'd0, 8'd3);
    step();
    chk("edge_s1_pe", period_end, 1'b1);
    chk("edge_s1_pwm", pwm_out, 4'h0);
    wr(2'd1, 8'd0);
    step();
    chk("edge_s2_pe", period_end, 1'b0);
    chk("edge_s2_pwm", pwm_out, 4'h0);
    wr(2'd2, 8'd10);
    step();
    chk("edge_s3_pe", period_end, 1'b0);
    chk("edge_s3_pwm", pwm_out, 4'h0);
    duty_wr = 1'b0;
    for (int k = 4; k <= 41; k++) begin
      step();
      exp_pe     = (k % 10 == 1);
      exp_pwm    = 4'h0;
      exp_pwm[0] = (k >= 12 && k <= 14) || (k >= 22 && k <= 24) || (k >= 32 && k <= 38);
      exp_pwm[2] = (k >= 12);
      chk("edge_pwm", pwm_out, exp_pwm);
      chk("edge_pe", period_end, exp_pe);
      if (k == 25) wr(2'd0, 8'd7);
      if (k == 26) duty_wr = 1'b0;
    end

    // Center mode, period 4, ch0 duty 2
    restart(2'd1, 8'd4);
    wr(2'd0, 8'd2);
    step();
    duty_wr = 1'b0;
    chk("ctr_s1_pe", period_end, 1'b1);
    chk("ctr_s1_pwm", pwm_out, 4'h0);
    for (int k = 2; k <= 33; k++) begin
      step();
      exp_pe  = (k % 8 == 1);
      exp_pwm = 4'h0;
      if (k >= 10) exp_pwm[0] = (ctab[(k - 10) % 8] < 2);
      chk("ctr_pwm", pwm_out, exp_pwm);
      chk("ctr_pe", period_end, exp_pe);
    end

    // Sigma-delta, ch0 duty 64 -> 1 of 4 cycles high
    restart(2'd2, 8'd9);
    wr(2'd0, 8'd64);
    step();
    duty_wr = 1'b0;
    chk("sd_s1_pe", period_end, 1'b1);
    for (int k = 2; k <= 25; k++) begin
      step();
      exp_pwm    = 4'h0;
      exp_pwm[0] = (k >= 6) && (k % 4 == 2);
      chk("sd_pwm", pwm_out, exp_pwm);
      chk("sd_pe", period_end, 1'b0);
    end

    // Reserved mode: outputs forced low
    mode = 2'd3;
    for (int k = 26; k <= 30; k++) begin
      step();
      exp_pwm    = 4'h0;
      exp_pwm[0] = (k == 26);
      chk("rsvd_pwm", pwm_out, exp_pwm);
      chk("rsvd_pe", period_end, 1'b0);
    end

    // Back to edge mode, period 2; ch0 duty 64 > period -> constant high
    mode   = 2'd0;
    period = 8'd2;
    for (int k = 31; k <= 40; k++) begin
      step();
      exp_pwm    = 4'h0;
      exp_pwm[0] = (k >= 32);
      exp_pe     = (k >= 34) && ((k - 34) % 3 == 0);
      chk("e2_pwm", pwm_out, exp_pwm);
      chk("e2_pe", period_end, exp_pe);
    end

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pwm", pwm_out, 4'h0);
    chk("async_rst_pe", period_end, 1'b0);
    @(negedge clk);
    mode   = 2'd0;
    period = 8'd9;
    rst    = 1'b0;
    cyc    = 0;
    for (int k = 1; k <= 25; k++) begin
      step();
      chk("post_rst_pwm", pwm_out, 4'h0);
      chk("post_rst_pe", period_end, (k % 10 == 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
